// File: rtl/proc_control_fsm.sv
// ---------------------------------------------------------------------------
// proc_control_fsm
//
// Multi-cycle control unit for the 16-bit bus datapath. It captures a 9-bit
// instruction word from din while idle, sequences it over up to three
// execution cycles (T1..T3), and pulses done in the final cycle. It is the
// sole driver of the register bank's select key and write strobe, and also
// drives the A/G operand latch enables, the ALU op and the bus mux select.
//
// Instruction word (IR): [8:6] opcode, [5:3] Rx, [2:0] Ry.
//   000 mv   Rx,Ry   : T1 G<=Ry, T2 Rx<=G
//   001 mvi  Rx,#D   : T1 Rx<=din (immediate must be on din during T1)
//   010 add  Rx,Ry   : T1 A<=Rx, T2 G<=A+Ry, T3 Rx<=G
//   011 sub  Rx,Ry   : T1 A<=Rx, T2 G<=A-Ry, T3 Rx<=G
//   100 mvnz Rx,Ry   : like mv, T2 write only when g_nz (CTRL_MVNZ_EN only)
//   others           : NOP, done in T1
//
// Build option: define CTRL_MVNZ_EN to enable opcode 100 as mvnz. Without
// it, opcode 100 is a NOP and g_nz is ignored.
//
// Handshake: run is a level request sampled only at a clock edge in IDLE;
// there is no ready/ack other than busy (high whenever not IDLE) and done
// (one-cycle pulse in the last cycle of each accepted instruction).
//
// Ports:
//   clock     in   rising-edge clock (shared with the register bank)
//   resetn    in   asynchronous active-low reset
//   run       in   start request
//   din       in   instruction word (IDLE) / immediate word (T1 of mvi)
//   g_nz      in   G register non-zero flag (mvnz only)
//   bank_key  out  register select for the bank (read and write)
//   bank_w    out  register bank write enable
//   a_en      out  A latch load enable
//   g_en      out  G latch load enable
//   alu_op    out  00 pass, 01 A+bus, 10 A-bus
//   bus_sel   out  00 bank, 01 din, 10 G
//   done      out  final-cycle pulse
//   busy      out  state != IDLE
//   fsm_state out  current FSM state (debug observation)
// ---------------------------------------------------------------------------
module proc_control_fsm #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  input  logic              g_nz,
  output logic [SEL_W-1:0]  bank_key,
  output logic              bank_w,
  output logic              a_en,
  output logic              g_en,
  output logic [1:0]        alu_op,
  output logic [1:0]        bus_sel,
  output logic              done,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] T1   = 2'd1;
  localparam logic [1:0] T2   = 2'd2;
  localparam logic [1:0] T3   = 2'd3;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  localparam logic [1:0] BUS_BANK = 2'b00;
  localparam logic [1:0] BUS_DIN  = 2'b01;
  localparam logic [1:0] BUS_G    = 2'b10;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [8:0] ir;

  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;

  assign opcode = ir[8:6];
  assign rx     = ir[5:3];
  assign ry     = ir[2:0];

  // Upper din bits are never decoded; g_nz only matters with mvnz enabled.
`ifdef CTRL_MVNZ_EN
  logic unused_bits;
  assign unused_bits = &{1'b0, din[DATA_W-1:9]};
`else
  logic unused_bits;
  assign unused_bits = &{1'b0, din[DATA_W-1:9], g_nz};
`endif

  // State and IR registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      ir    <= 9'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && run) begin
        ir <= din[8:0];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: state_nxt = run ? T1 : IDLE;
      T1: begin
        case (opcode)
          OP_MV, OP_ADD, OP_SUB: state_nxt = T2;
`ifdef CTRL_MVNZ_EN
          OP_MVNZ:               state_nxt = T2;
`endif
          default:               state_nxt = IDLE;
        endcase
      end
      T2: begin
        case (opcode)
          OP_ADD, OP_SUB: state_nxt = T3;
          default:        state_nxt = IDLE;
        endcase
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode of (state, IR). Everything defaults to 0, so IDLE and
  // reset produce all-zero outputs without any special casing.
  always_comb begin
    bank_key = '0;
    bank_w   = 1'b0;
    a_en     = 1'b0;
    g_en     = 1'b0;
    alu_op   = ALU_PASS;
    bus_sel  = BUS_BANK;
    done     = 1'b0;
    case (state)
      T1: begin
        case (opcode)
          OP_MV: begin
            bank_key = SEL_W'(ry);
            g_en     = 1'b1;
          end
`ifdef CTRL_MVNZ_EN
          OP_MVNZ: begin
            bank_key = SEL_W'(ry);
            g_en     = 1'b1;
          end
`endif
          OP_MVI: begin
            bank_key = SEL_W'(rx);
            bus_sel  = BUS_DIN;
            bank_w   = 1'b1;
            done     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bank_key = SEL_W'(rx);
            a_en     = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
      T2: begin
        case (opcode)
          OP_MV: begin
            bank_key = SEL_W'(rx);
            bus_sel  = BUS_G;
            bank_w   = 1'b1;
            done     = 1'b1;
          end
`ifdef CTRL_MVNZ_EN
          OP_MVNZ: begin
            bank_key = SEL_W'(rx);
            bus_sel  = BUS_G;
            bank_w   = g_nz;
            done     = 1'b1;
          end
`endif
          OP_ADD, OP_SUB: begin
            bank_key = SEL_W'(ry);
            alu_op   = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
            g_en     = 1'b1;
          end
          default: ;
        endcase
      end
      T3: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          bank_key = SEL_W'(rx);
          bus_sel  = BUS_G;
          bank_w   = 1'b1;
          done     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_proc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_proc_control_fsm
//
// Directed bench for proc_control_fsm. Inputs are changed and outputs are
// observed 1 time unit after each rising edge. Each check compares a packed
// vector {bank_key, bank_w, a_en, g_en, alu_op, bus_sel, done, busy} against
// a hand-computed value.
// ---------------------------------------------------------------------------
module tb_proc_control_fsm;

  logic        clock;
  logic        resetn;
  logic        run;
  logic [15:0] din;
  logic        g_nz;
  logic [2:0]  bank_key;
  logic        bank_w;
  logic        a_en;
  logic        g_en;
  logic [1:0]  alu_op;
  logic [1:0]  bus_sel;
  logic        done;
  logic        busy;
  logic [1:0]  fsm_state;

  int n_cmp;
  int n_err;

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  proc_control_fsm #(.DATA_W(16), .SEL_W(3)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .run       (run),
    .din       (din),
    .g_nz      (g_nz),
    .bank_key  (bank_key),
    .bank_w    (bank_w),
    .a_en      (a_en),
    .g_en      (g_en),
    .alu_op    (alu_op),
    .bus_sel   (bus_sel),
    .done      (done),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  logic [11:0] obs;
  assign obs = {bank_key, bank_w, a_en, g_en, alu_op, bus_sel, done, busy};

  // driver: advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // check: key, bank_w, a_en, g_en, alu_op, bus_sel, done, busy
  task automatic chk(input string tag, input logic [2:0] key, input logic bw,
                     input logic ae, input logic ge, input logic [1:0] alu,
                     input logic [1:0] bsel, input logic dn, input logic bsy);
    logic [11:0] exp_v;
    exp_v = {key, bw, ae, ge, alu, bsel, dn, bsy};
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed key=%0d w=%b a=%b g=%b alu=%b bus=%b done=%b busy=%b expected key=%0d w=%b a=%b g=%b alu=%b bus=%b done=%b busy=%b",
             tag, bank_key, bank_w, a_en, g_en, alu_op, bus_sel, done, busy,
             key, bw, ae, ge, alu, bsel, dn, bsy);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    resetn = 1'b0;
    run    = 1'b0;
    din    = 16'h0000;
    g_nz   = 1'b0;

    // reset state
    #3;
    chk("reset", 3'd0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // reset landing mid-instruction (add R2,R1)
    din = 16'h0091; run = 1'b1;
    tick();
    run = 1'b0;
    chk("rst_add_t1", 3'd2, 0, 1, 0, 2'b00, 2'b00, 0, 1);
    tick();
    chk("rst_add_t2", 3'd1, 0, 0, 1, 2'b01, 2'b00, 0, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_async", 3'd0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    tick();
    tick();
    #2;
    resetn = 1'b1;
    tick();
    chk("rst_idle0", 3'd0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    tick();
    chk("rst_idle1", 3'd0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

    // mvi R1,#0x1234
    din = 16'h0048; run = 1'b1;
    tick();
    din = 16'h1234; run = 1'b0;
    chk("mvi_t1", 3'd1, 1, 0, 0, 2'b00, 2'b01, 1, 1);
    tick();
    chk("mvi_idle", 3'd0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

    // add R2,R1
    din = 16'h0091; run = 1'b1;
    tick();
    run = 1'b0; din = 16'h0000;
    chk("add_t1", 3'd2, 0, 1, 0, 2'b00, 2'b00, 0, 1);
    tick();
    chk("add_t2", 3'd1, 0, 0, 1, 2'b01, 2'b00, 0, 1);
    tick();
    chk("add_t3", 3'd2, 1, 0, 0, 2'b00, 2'b10, 1, 1);
    tick();
    chk("add_idle", 3'd0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

    // sub R2,R1 then mv R0,R3 with run held high
    din = 16'h00D1; run = 1'b1;
    tick();
    din = 16'h0003;
    chk("sub_t1", 3'd2, 0, 1, 0, 2'b00, 2'b00, 0, 1);
    tick();
    chk("sub_t2", 3'd1, 0, 0, 1, 2'b10, 2'b00, 0, 1);
    tick();
    chk("sub_t3", 3'd2, 1, 0, 0, 2'b00, 2'b10, 1, 1);
    tick();
    chk("b2b_gap", 3'd0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    tick();
    din = 16'h0091;
    chk("mv_t1", 3'd3, 0, 0, 1, 2'b00, 2'b00, 0, 1);
    tick();
    chk("mv_t2", 3'd0, 1, 0, 0, 2'b00, 2'b10, 1, 1);
    tick();
    run = 1'b0;
    chk("mv_idle", 3'd0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    tick();
    chk("mv_idle2", 3'd0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

    // unknown opcode 111: NOP
    din = 16'h01C0; run = 1'b1;
    tick();
    run = 1'b0;
    chk("nop_t1", 3'd0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
    tick();
    chk("nop_idle", 3'd0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

`ifdef CTRL_MVNZ_EN
    // mvnz R1,R2 with G zero, then non-zero
    g_nz = 1'b0;
    din = 16'h010A; run = 1'b1;
    tick();
    run = 1'b0;
    chk("mvnz0_t1", 3'd2, 0, 0, 1, 2'b00, 2'b00, 0, 1);
    tick();
    chk("mvnz0_t2", 3'd1, 0, 0, 0, 2'b00, 2'b10, 1, 1);
    tick();
    g_nz = 1'b1;
    din = 16'h010A; run = 1'b1;
    tick();
    run = 1'b0;
    chk("mvnz1_t1", 3'd2, 0, 0, 1, 2'b00, 2'b00, 0, 1);
    tick();
    chk("mvnz1_t2", 3'd1, 1, 0, 0, 2'b00, 2'b10, 1, 1);
    tick();
    chk("mvnz_idle", 3'd0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
`else
    // opcode 100 is a NOP; g_nz has no effect
    g_nz = 1'b1;
    din = 16'h010A; run = 1'b1;
    tick();
    run = 1'b0;
    chk("op100_t1", 3'd0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
    tick();
    chk("op100_idle", 3'd0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
`endif

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
